// File: rtl/fetch_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Data normally wins; a saturating counter forces fetch through after IF_STARVE_MAX data grants.
module fetch_mem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int IF_STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_XFER = 2'd1;
  localparam logic [1:0] D_XFER  = 2'd2;

  localparam int              CNT_W      = $clog2(IF_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(IF_STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              if_gnt_q, if_gnt_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_gnt_q, d_gnt_d;
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              fetch_forced;

  assign fetch_forced = if_req && (starve_cnt_q == STARVE_LIM);

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    flush_pend_d = flush_pend_q;
    if_gnt_d     = 1'b0;
    if_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_gnt_d      = 1'b0;
    d_valid_d    = 1'b0;
    d_rdata_d    = d_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (d_req && !fetch_forced) begin
          state_d     = D_XFER;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          d_gnt_d     = 1'b1;
          if (if_req && starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (if_req) begin
          state_d      = IF_XFER;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_wdata_d  = '0;
          if_gnt_d     = 1'b1;
          starve_cnt_d = '0;
        end
      end
      IF_XFER: begin
        if (mem_ready) begin
          state_d      = IDLE;
          mem_req_d    = 1'b0;
          flush_pend_d = 1'b0;
          // A flush seen during the access or on its final cycle drops the result.
          if (!(flush_pend_q || if_flush)) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else if (if_flush) begin
          flush_pend_d = 1'b1;
        end
      end
      D_XFER: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_valid_d = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      flush_pend_q <= 1'b0;
      if_gnt_q     <= 1'b0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_gnt_q      <= 1'b0;
      d_valid_q    <= 1'b0;
      d_rdata_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      flush_pend_q <= flush_pend_d;
      if_gnt_q     <= if_gnt_d;
      if_valid_q   <= if_valid_d;
      if_rdata_q   <= if_rdata_d;
      d_gnt_q      <= d_gnt_d;
      d_valid_q    <= d_valid_d;
      d_rdata_q    <= d_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_fetch_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_flush, d_req, d_we, mem_ready;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          if_gnt, if_valid, d_gnt, d_valid, mem_req, mem_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int total = 0;
  int bad = 0;

  // model: one in-flight transaction record plus the visible output values
  int            m_owner;  // 0 none, 1 fetch, 2 data
  int            m_starve;
  bit            m_flushed;
  logic          m_if_gnt, m_if_valid, m_d_gnt, m_d_valid, m_mem_req, m_we;
  logic [DW-1:0] m_if_rdata, m_d_rdata, m_wdata;
  logic [AW-1:0] m_addr;

  always #5 clk = ~clk;

  fetch_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .IF_STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_owner = 0; m_starve = 0; m_flushed = 0;
    m_if_gnt = 0; m_if_valid = 0; m_d_gnt = 0; m_d_valid = 0;
    m_mem_req = 0; m_we = 0; m_if_rdata = '0; m_d_rdata = '0; m_wdata = '0; m_addr = '0;
  endtask

  // Advance the model by one clock using the inputs the DUT will sample.
  task automatic model_step();
    if (!reset) begin
      model_clear();
      return;
    end
    m_if_gnt = 0; m_if_valid = 0; m_d_gnt = 0; m_d_valid = 0;
    if (m_owner == 0) begin
      if (d_req && !(if_req && m_starve == SMAX)) begin
        m_owner = 2; m_mem_req = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
        m_d_gnt = 1;
        if (if_req && m_starve < SMAX) m_starve++;
      end else if (if_req) begin
        m_owner = 1; m_mem_req = 1; m_we = 0; m_addr = if_addr; m_wdata = '0;
        m_if_gnt = 1; m_starve = 0;
      end
    end else begin
      if (m_owner == 1 && if_flush) m_flushed = 1;
      if (mem_ready) begin
        if (m_owner == 1 && !m_flushed) begin
          m_if_valid = 1; m_if_rdata = mem_rdata;
        end
        if (m_owner == 2) begin
          m_d_valid = 1;
          if (!m_we) m_d_rdata = mem_rdata;
        end
        m_flushed = 0; m_owner = 0; m_mem_req = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("if_gnt", if_gnt, m_if_gnt);
    chk("if_valid", if_valid, m_if_valid);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_gnt", d_gnt, m_d_gnt);
    chk("d_valid", d_valid, m_d_valid);
    chk("d_rdata", d_rdata, m_d_rdata);
    chk("mem_req", mem_req, m_mem_req);
    chk("busy", busy, m_owner != 0);
    if (m_mem_req) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; if_flush = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  initial begin
    string order;
    int    n;
    bit    if_pend, d_pend;

    reset = 0;
    idle_inputs();
    model_clear();
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);

    // 1: fetch from reset
    @(negedge clk);
    reset = 1; if_req = 1; if_addr = 32'h0; mem_ready = 1; mem_rdata = 32'hE3A00001;
    tick();
    chk("t1_if_gnt", if_gnt, 1);
    chk("t1_mem_addr", mem_addr, 32'h0);
    if_req = 0;
    tick();
    chk("t1_if_valid", if_valid, 1);
    chk("t1_if_rdata", if_rdata, 32'hE3A00001);

    // 2: write with mem_ready held off for 3 cycles
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; mem_ready = 0;
    tick();
    chk("t2_d_gnt", d_gnt, 1);
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_mem_req", mem_req, 1);
      chk("t2_mem_we", mem_we, 1);
      chk("t2_mem_addr", mem_addr, 32'h100);
      chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("t2_no_valid", d_valid, 0);
      mem_ready = (i == 3);
      tick();
    end
    chk("t2_d_valid", d_valid, 1);
    chk("t2_d_rdata", d_rdata, 0);
    chk("t2_mem_req_off", mem_req, 0);
    mem_ready = 0;

    // 3: both requesters saturate the bus
    if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h300;
    mem_ready = 1; mem_rdata = 32'hCAFE0000;
    order = ""; n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      tick();
      if (if_gnt) begin order = {order, "I"}; n++; end
      if (d_gnt)  begin order = {order, "D"}; n++; end
    end
    total++;
    if (order != "DDDDIDDDDI") begin
      bad++;
      $display("FAIL t3_grant_order: got %s expected DDDDIDDDDI", order);
    end
    if_req = 0; d_req = 0;
    tick();
    chk("t3_if_rdata", if_rdata, 32'hCAFE0000);

    // 4: flush during a fetch
    if_req = 1; if_addr = 32'h40; mem_ready = 0;
    tick();
    chk("t4_if_gnt", if_gnt, 1);
    if_req = 0; if_flush = 1;
    tick();
    if_flush = 0; mem_ready = 1; mem_rdata = 32'h12345678;
    tick();
    chk("t4_no_valid", if_valid, 0);
    chk("t4_if_rdata_kept", if_rdata, 32'hCAFE0000);
    chk("t4_idle", busy, 0);
    if_req = 1; if_addr = 32'h44; mem_rdata = 32'h11112222;
    tick();
    chk("t4_gnt2", if_gnt, 1);
    if_req = 0;
    tick();
    chk("t4_valid2", if_valid, 1);
    chk("t4_rdata2", if_rdata, 32'h11112222);

    // 5: reset while a data read waits on memory
    d_req = 1; d_we = 0; d_addr = 32'h200; mem_ready = 0;
    tick();
    chk("t5_d_gnt", d_gnt, 1);
    d_req = 0;
    tick();
    chk("t5_waiting", mem_req, 1);
    reset = 0;
    #1;
    chk("t5_mem_req_drop", mem_req, 0);
    chk("t5_busy_drop", busy, 0);
    chk("t5_no_valid", d_valid, 0);
    mem_ready = 1;
    tick();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_if_gnt", if_gnt, 0);
      chk("t5_no_d_gnt", d_gnt, 0);
    end

    // randomized traffic
    if_pend = 0; d_pend = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_addr = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_we = $urandom_range(0, 1) == 1; d_addr = $urandom; d_wdata = $urandom;
      end
      if_req = if_pend; d_req = d_pend;
      if_flush = $urandom_range(0, 5) == 0;
      mem_ready = $urandom_range(0, 1) == 1;
      mem_rdata = $urandom;
      reset = !($urandom_range(0, 299) == 0);
      tick();
      if (m_if_gnt) if_pend = 0;
      if (m_d_gnt) d_pend = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
